mem_port_arbiter: RTL and testbench

- Shares the single SLC-3 on-chip memory port between two requesters: the CPU control unit (port 0: fetch, LDR, STR) and the MMIO/IO master (port 1: program loader, debug reader).
- Sequences each access as one grant cycle, a fixed number of memory wait cycles, and a one-cycle completion pulse.
- Sits between control/datapath and the BRAM wrapper, replacing direct mem_mem_ena/mem_wr_ena drive.

---
 rtl/slc3_mem_pkg.sv | 20 ++
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared types and default sizing for the SLC-3 memory port arbiter.
// Optional round-robin arbitration in mem_port_arbiter is enabled by MEM_ARB_RR_EN.
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_IO  = 1'b1
    } req_id_t;

    localparam int MEM_WAIT_DEF = 3;
    localparam int AW_DEF       = 16;
    localparam int DW_DEF       = 16;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single SLC-3 memory port: grant, MEM_WAIT access cycles, done pulse.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module mem_port_arbiter
    import slc3_mem_pkg::*;
#(
    parameter int MEM_WAIT = MEM_WAIT_DEF,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_done,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic [DW-1:0] io_rdata,
    output logic          io_done,
    output logic          mem_ena,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [3:0] LAST_CNT = 4'(MEM_WAIT - 1);

    arb_state_t    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    req_id_t       id_q, id_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] io_rdata_q, io_rdata_d;
    logic          cpu_done_q, cpu_done_d;
    logic          io_done_q, io_done_d;
    logic          mem_ena_q, mem_ena_d;
    logic          mem_we_q, mem_we_d;
    logic          busy_q, busy_d;
    req_id_t       grant_s;
`ifdef MEM_ARB_RR_EN
    req_id_t       last_grant_q, last_grant_d;
`endif

    // Pick the winner among the currently pending requesters.
    always_comb begin
`ifdef MEM_ARB_RR_EN
        if (cpu_req && io_req) begin
            grant_s = (last_grant_q == REQ_CPU) ? REQ_IO : REQ_CPU;
        end else if (cpu_req) begin
            grant_s = REQ_CPU;
        end else begin
            grant_s = REQ_IO;
        end
`else
        if (cpu_req) begin
            grant_s = REQ_CPU;
        end else begin
            grant_s = REQ_IO;
        end
`endif
    end

    // Next-state and next-output computation for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        io_rdata_d  = io_rdata_q;
        cpu_done_d  = 1'b0;
        io_done_d   = 1'b0;
        mem_ena_d   = 1'b0;
        mem_we_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req || io_req) begin
                    id_d      = grant_s;
                    we_d      = (grant_s == REQ_CPU) ? cpu_we    : io_we;
                    addr_d    = (grant_s == REQ_CPU) ? cpu_addr  : io_addr;
                    wdata_d   = (grant_s == REQ_CPU) ? cpu_wdata : io_wdata;
                    cnt_d     = 4'd0;
                    mem_ena_d = 1'b1;
                    mem_we_d  = we_d;
                    state_d   = ACCESS;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = grant_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    // Data is captured while the address is still presented.
                    if (!we_q && (id_q == REQ_CPU)) begin
                        cpu_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        io_rdata_d = mem_rdata;
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                    cpu_done_d = (id_q == REQ_CPU);
                    io_done_d  = (id_q == REQ_IO);
                    cnt_d      = 4'd0;
                    state_d    = DONE;
                end else begin
                    cnt_d     = cnt_q + 4'd1;
                    mem_ena_d = 1'b1;
                    mem_we_d  = we_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any access at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            id_q        <= REQ_CPU;
            we_q        <= 1'b0;
            addr_q      <= {AW{1'b0}};
            wdata_q     <= {DW{1'b0}};
            cpu_rdata_q <= {DW{1'b0}};
            io_rdata_q  <= {DW{1'b0}};
            cpu_done_q  <= 1'b0;
            io_done_q   <= 1'b0;
            mem_ena_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= REQ_IO;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            io_rdata_q  <= io_rdata_d;
            cpu_done_q  <= cpu_done_d;
            io_done_q   <= io_done_d;
            mem_ena_q   <= mem_ena_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign io_rdata  = io_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign io_done   = io_done_q;
    assign mem_ena   = mem_ena_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int M = 3;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, io_req, io_we;
    logic [15:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
    logic [15:0] cpu_rdata, io_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_done, io_done, mem_ena, mem_we, busy;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] ref_mem [0:255];
    logic [15:0] exp_cpu_rdata, exp_io_rdata;
    bit          last_g;   // 0 = CPU, 1 = IO

    logic [15:0] bram [0:255];

    mem_port_arbiter #(.MEM_WAIT(M), .AW(16), .DW(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_done(io_done),
        .mem_ena(mem_ena), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int i);
        if (i == 5) return 16'h1234;
        return 16'(i * 16'h0101) ^ 16'h5A5A;
    endfunction

    // Behavioural BRAM: combinational read, write on clock edge, reloaded during reset.
    assign mem_rdata = bram[mem_addr[7:0]];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) bram[i] <= init_word(i);
        end else if (mem_ena && mem_we) begin
            bram[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic bit pick(input bit pc, input bit pi, input bit lg);
        if (pc && pi) begin
`ifdef MEM_ARB_RR_EN
            return ~lg;
`else
            return 1'b0;
`endif
        end
        return pc ? 1'b0 : 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        exp_cpu_rdata = 16'h0000;
        exp_io_rdata  = 16'h0000;
        last_g        = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_mem_ena"}, {31'd0, mem_ena}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
        check({tag, "_done"}, {30'd0, cpu_done, io_done}, 32'd0);
        check({tag, "_cpu_rdata"}, {16'd0, cpu_rdata}, 32'd0);
        check({tag, "_io_rdata"}, {16'd0, io_rdata}, 32'd0);
    endtask

    // Called at a negedge with the DUT idle; runs `grants` transactions, re-raising when hold=1.
    task automatic run(input bit c_en, input bit c_we, input logic [15:0] c_addr, input logic [15:0] c_wd,
                       input bit i_en, input bit i_we, input logic [15:0] i_addr, input logic [15:0] i_wd,
                       input bit withdraw, input bit hold, input int grants);
        bit pc, pi, w, we_w;
        logic [15:0] a, d;
        pc = c_en; pi = i_en;
        cpu_req = c_en; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        io_req  = i_en; io_we  = i_we; io_addr  = i_addr; io_wdata  = i_wd;
        for (int g = 0; g < grants; g++) begin
            if (!pc && !pi) break;
            w    = pick(pc, pi, last_g);
            we_w = w ? i_we : c_we;
            a    = w ? i_addr : c_addr;
            d    = w ? i_wd : c_wd;
            last_g = w;
            @(posedge clk);
            for (int c = 1; c <= M; c++) begin
                @(negedge clk);
                check("acc_mem_ena", {31'd0, mem_ena}, 32'd1);
                check("acc_mem_we", {31'd0, mem_we}, {31'd0, we_w});
                check("acc_mem_addr", {16'd0, mem_addr}, {16'd0, a});
                check("acc_mem_wdata", {16'd0, mem_wdata}, {16'd0, d});
                check("acc_busy", {31'd0, busy}, 32'd1);
                check("acc_done", {30'd0, cpu_done, io_done}, 32'd0);
                if (withdraw && c == 1 && !w) begin
                    cpu_req  = 1'b0;
                    cpu_addr = 16'hFFFF;
                end
            end
            @(negedge clk);
            check("done_cpu", {31'd0, cpu_done}, {31'd0, ~w});
            check("done_io", {31'd0, io_done}, {31'd0, w});
            check("done_mem_ena", {31'd0, mem_ena}, 32'd0);
            check("done_busy", {31'd0, busy}, 32'd1);
            if (we_w) ref_mem[a[7:0]] = d;
            else if (w) exp_io_rdata = ref_mem[a[7:0]];
            else exp_cpu_rdata = ref_mem[a[7:0]];
            if (w) begin io_req = 1'b0; pi = 1'b0; end
            else begin cpu_req = 1'b0; pc = 1'b0; end
            @(negedge clk);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_done", {30'd0, cpu_done, io_done}, 32'd0);
            check("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, exp_cpu_rdata});
            check("io_rdata", {16'd0, io_rdata}, {16'd0, exp_io_rdata});
            if (hold && g < grants - 1) begin
                if (w) begin io_req = 1'b1; pi = 1'b1; end
                else begin cpu_req = 1'b1; pc = 1'b1; end
            end
        end
        cpu_req = 1'b0;
        io_req  = 1'b0;
    endtask

    initial begin
        bit m_we;
        int mode;
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
        io_req  = 1'b0; io_we  = 1'b0; io_addr  = 16'h0000; io_wdata  = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_mem_ena", {31'd0, mem_ena}, 32'd0);

        // CPU read of preloaded word
        run(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1);
        check("cpu_read_x0005", {16'd0, cpu_rdata}, 32'h1234);

        // IO write then CPU read of the same location
        run(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 1'b0, 1);
        run(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1);
        check("cpu_read_x0020", {16'd0, cpu_rdata}, 32'hBEEF);
        check("io_rdata_unchanged", {16'd0, io_rdata}, 32'h0000);

        // Simultaneous reads: one grant at a time, loser served next
        run(1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 1'b0, 16'h0022, 16'h0000, 1'b0, 1'b0, 2);

        // Withdrawal one cycle into ACCESS
        run(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1);

        // Randomized mix
        for (int n = 0; n < 24; n++) begin
            mode = $urandom_range(0, 2);
            m_we = 1'($urandom_range(0, 1));
            run(mode != 1, m_we, 16'($urandom_range(0, 255)), 16'($urandom),
                mode != 0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom),
                (mode == 0) && ($urandom_range(0, 3) == 0), 1'b0, (mode == 2) ? 2 : 1);
        end

        // Both requests held continuously for 8 grants
        run(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 16'h0041, 16'h0000, 1'b0, 1'b1, 8);

        // Reset in the middle of an access
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_mem_ena", {31'd0, mem_ena}, 32'd0);
        check("async_mem_we", {31'd0, mem_we}, 32'd0);
        cpu_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("mid_rst");
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_no_done", {30'd0, cpu_done, io_done}, 32'd0);
        check("mid_rst_idle", {31'd0, busy}, 32'd0);
        run(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1);
        check("read_after_rst", {16'd0, cpu_rdata}, 32'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
